// File: rtl/alu_operand_issue_pkg.sv
// Shared types for the ALU operand issue stage.
//   alu_sel_e  : ALU operation encoding (carried through unchanged)
//   op1_sel_e  : operand 1 source select (RS1 / PC / ZERO, 2'b11 reserved)
//   op2_sel_e  : operand 2 source select (RS2 / IMM / FOUR, 2'b11 reserved)
//   issue_op_t : one fully resolved micro-op as presented to the ALU
package alu_operand_issue_pkg;

  localparam int unsigned PKG_XLEN      = 32;
  localparam int unsigned PKG_REG_IDX_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_COPY_B = 4'd10
  } alu_sel_e;

  typedef enum logic [1:0] {
    OP1_RS1  = 2'd0,
    OP1_PC   = 2'd1,
    OP1_ZERO = 2'd2
  } op1_sel_e;

  typedef enum logic [1:0] {
    OP2_RS2  = 2'd0,
    OP2_IMM  = 2'd1,
    OP2_FOUR = 2'd2
  } op2_sel_e;

  typedef struct packed {
    logic [PKG_XLEN-1:0]      op1;
    logic [PKG_XLEN-1:0]      op2;
    alu_sel_e                 alu_sel;
    logic [PKG_REG_IDX_W-1:0] rd;
    logic                     rd_we;
  } issue_op_t;

endpackage

// File: rtl/alu_operand_issue_skid_buffer_2.sv
// Generic 2-entry valid/ready skid buffer.
//   clk, rst (async, active-low), flush (sync kill of all held entries)
//   in_valid/in_ready/in_data   : upstream side, in_ready is a flop output
//   out_valid/out_ready/out_data: downstream side, out_data is the main entry
// The main entry drives the outputs; the skid entry catches the one op that
// arrives while the main entry is stalled, so in_ready can be registered.
module skid_buffer_2
  import alu_operand_issue_pkg::*;
#(
  parameter type T         = issue_op_t,
  parameter T    RESET_VAL = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e state, next_state;
  T       main_q, skid_q;
  logic   accept, drain;
  logic   load_main_in, load_main_skid, load_skid;

  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;

  always_comb begin
    next_state     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      next_state = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            next_state   = ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            load_skid  = 1'b1;
            next_state = TWO;
          end else if (drain) begin
            next_state = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only a drain can move the state
          if (drain) begin
            load_main_skid = 1'b1;
            next_state     = ONE;
          end
        end
        default: next_state = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= next_state;
      in_ready <= (next_state != TWO);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else begin
      // flush returns the outputs to the idle value so no write enable leaks
      if (flush) begin
        main_q <= RESET_VAL;
      end else if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/alu_operand_issue.sv
// Execute-entry stage in front of the ALU.
//   clk, rst (async, active-low), flush (sync kill)
//   in_valid/in_ready + rs1/rs2 index/data, pc, imm, op1_sel, op2_sel,
//     alu_sel_in, rd_in, rd_we_in : decoded micro-op from decode
//   fwd_we/fwd_rd/fwd_data         : writeback bypass
//   out_valid/out_ready + op1, op2, alu_sel, rd_out, rd_we_out : to the ALU
// Operands are resolved combinationally at acceptance (including writeback
// forwarding) and then held in a 2-entry skid buffer.
// Field widths of issue_op_t come from the package; XLEN/REG_IDX_W must
// match PKG_XLEN/PKG_REG_IDX_W.
module alu_operand_issue
  import alu_operand_issue_pkg::*;
#(
  parameter int unsigned XLEN      = PKG_XLEN,
  parameter int unsigned REG_IDX_W = PKG_REG_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_IDX_W-1:0] rs1_idx,
  input  logic [REG_IDX_W-1:0] rs2_idx,
  input  logic [XLEN-1:0]      rs1_data,
  input  logic [XLEN-1:0]      rs2_data,
  input  logic [XLEN-1:0]      pc,
  input  logic [XLEN-1:0]      imm,
  input  op1_sel_e             op1_sel,
  input  op2_sel_e             op2_sel,
  input  alu_sel_e             alu_sel_in,
  input  logic [REG_IDX_W-1:0] rd_in,
  input  logic                 rd_we_in,
  input  logic                 fwd_we,
  input  logic [REG_IDX_W-1:0] fwd_rd,
  input  logic [XLEN-1:0]      fwd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      op1,
  output logic [XLEN-1:0]      op2,
  output alu_sel_e             alu_sel,
  output logic [REG_IDX_W-1:0] rd_out,
  output logic                 rd_we_out
);

  logic [XLEN-1:0] rs1v, rs2v;
  issue_op_t       in_op, out_op;

  always_comb begin
    // x0 is hardwired zero, so a writeback to x0 must never be forwarded
    rs1v = rs1_data;
    if (fwd_we && (fwd_rd == rs1_idx) && (rs1_idx != '0)) begin
      rs1v = fwd_data;
    end
    rs2v = rs2_data;
    if (fwd_we && (fwd_rd == rs2_idx) && (rs2_idx != '0)) begin
      rs2v = fwd_data;
    end
  end

  always_comb begin
    in_op = '0;
    case (op1_sel)
      OP1_RS1:  in_op.op1 = rs1v;
      OP1_PC:   in_op.op1 = pc;
      OP1_ZERO: in_op.op1 = '0;
      default:  in_op.op1 = '0;
    endcase
    case (op2_sel)
      OP2_RS2:  in_op.op2 = rs2v;
      OP2_IMM:  in_op.op2 = imm;
      OP2_FOUR: in_op.op2 = {{(XLEN-3){1'b0}}, 3'd4};
      default:  in_op.op2 = '0;
    endcase
    in_op.alu_sel = alu_sel_in;
    in_op.rd      = rd_in;
    in_op.rd_we   = rd_we_in && (rd_in != '0);
  end

  skid_buffer_2 #(
    .T         (issue_op_t),
    .RESET_VAL ('0)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_op)
  );

  assign op1       = out_op.op1;
  assign op2       = out_op.op2;
  assign alu_sel   = out_op.alu_sel;
  assign rd_out    = out_op.rd;
  assign rd_we_out = out_op.rd_we;

endmodule

// File: doc/alu_operand_issue.md
Name: alu_operand_issue

Overview:
Execute-entry stage directly upstream of the ALU.
- Accepts decoded micro-ops from decode over a valid/ready handshake.
- Selects and forwards operands, then presents registered op1/op2/aluSel to the ALU along with writeback tags.
- Contains a 2-entry skid buffer, so in_ready is a pure register output and the stage sustains one op per cycle.

Parameters:
XLEN, 32, data width of operands, pc and imm
REG_IDX_W, 5, register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
flush  in  1  synchronous pipeline kill; drops all buffered ops
in_valid  in  1  decode offers a micro-op
in_ready  out  1  stage can accept (registered)
rs1_idx  in  REG_IDX_W  source 1 index
rs2_idx  in  REG_IDX_W  source 2 index
rs1_data  in  XLEN  register file read data 1
rs2_data  in  XLEN  register file read data 2
pc  in  XLEN  instruction address
imm  in  XLEN  sign-extended immediate
op1_sel  in  Op1Sel (2)  RS1 / PC / ZERO
op2_sel  in  Op2Sel (2)  RS2 / IMM / FOUR
alu_sel_in  in  ALUSel (4)  requested ALU operation
rd_in  in  REG_IDX_W  destination index
rd_we_in  in  1  destination write enable
fwd_we  in  1  writeback stage writes a register this cycle
fwd_rd  in  REG_IDX_W  writeback destination
fwd_data  in  XLEN  writeback value
out_valid  out  1  op1/op2/alu_sel valid toward ALU
out_ready  in  1  downstream accepts
op1  out  XLEN  ALU operand 1
op2  out  XLEN  ALU operand 2
alu_sel  out  ALUSel (4)  ALU operation
rd_out  out  REG_IDX_W  destination index
rd_we_out  out  1  destination write enable

Behaviour:
- Reset (rst low, async): in_ready=1, out_valid=0, op1=op2=0, alu_sel=ADD, rd_out=0, rd_we_out=0, FSM=EMPTY.
- Operand resolution is combinational on the input side:
  - rs1v = fwd_data if fwd_we && fwd_rd==rs1_idx && rs1_idx!=0, else rs1_data. rs2v is formed the same way.
  - op1 = RS1:rs1v, PC:pc, ZERO:0.
  - op2 = RS2:rs2v, IMM:imm, FOUR:4 (zero-extended to XLEN).
  - Reserved select encodings yield 0.
  - rd_we is forced 0 when rd_in==0.
- Accept = in_valid && in_ready. Drain = out_valid && out_ready.
- Storage: main register (drives outputs) and skid register, each holding {op1, op2, alu_sel, rd, rd_we}.
- FSM states: EMPTY (no op), ONE (main valid), TWO (main+skid valid).
  - EMPTY: accept -> load main, ONE.
  - ONE:
    - accept && drain -> load main, stay ONE.
    - accept && !drain -> load skid, TWO.
    - drain only -> EMPTY.
  - TWO:
    - drain -> main<=skid, ONE.
    - No accept is possible in TWO.
- Outputs: out_valid = state!=EMPTY. in_ready is registered, =1 in EMPTY/ONE and 0 in TWO (next-state based).
- Latency: an accepted op appears on outputs the cycle after acceptance. Throughput is 1 op/cycle with out_ready held high.
- Output stability: main contents must not change while out_valid && !out_ready.
- Forwarding captures the value at acceptance. An op sitting in skid does not re-forward, because decode stalls reads for hazards older than writeback.
- flush: next state EMPTY, out_valid=0, in_ready=1, rd_we_out=0. An accept in the same cycle is discarded. Flush takes priority over every transition.
- rst mid-transfer: immediate return to the reset values, no partial op emitted.
- alu_sel passes through unchanged. Validating the encoding is downstream's job.

Decomposition:
- Shared package (same one holding ALUSel): Op1Sel {RS1, PC, ZERO} and Op2Sel {RS2, IMM, FOUR} enums, and an IssueOp struct {op1, op2, alu_sel, rd, rd_we}.
- One natural sub-module: skid_buffer_2 (generic 2-entry valid/ready buffer over IssueOp).
- Operand mux and forwarding stay in the top.

Test Plan:
- Basic issue: after reset, op1_sel=RS1, op2_sel=IMM, rs1_data=0x10, imm=0xFFFFFFFC, alu_sel_in=ADD, rd=5, out_ready=1 -> next cycle out_valid=1, op1=0x10, op2=0xFFFFFFFC, rd_out=5, rd_we_out=1.
- Forwarding: rs1_idx=3, rs1_data=0x1, fwd_we=1, fwd_rd=3, fwd_data=0xDEAD -> op1=0xDEAD. Repeat with rs1_idx=0, fwd_rd=0 -> op1=rs1_data. rd_in=0, rd_we_in=1 -> rd_we_out=0.
- Backpressure: stream 4 ops (A–D) with out_ready=0 -> A on outputs and held stable; in_ready=0 after B is accepted; C is not accepted. Release out_ready -> A, B, C, D delivered in order, none lost or duplicated.
- Full throughput: 10 back-to-back ops, out_ready=1 throughout -> 10 outputs on 10 consecutive cycles, in_ready never drops.
- Flush: state TWO, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, no op delivered after release.
- Async reset: assert rst low mid-cycle while in TWO -> out_valid=0 and in_ready=1 immediately, before the next clock edge. PC path check: op1_sel=PC, op2_sel=FOUR, pc=0x100 -> op1=0x100, op2=4.
